// File: rtl/ov_frame_ctrl.sv
// Frame-level capture controller: single-shot/continuous sequencing with decimation,
// ping-pong bank scheduling, per-frame geometry checking and drop counting.
module ov_frame_ctrl #(
  parameter int H_PIX   = 640,
  parameter int V_LINES = 480,
  parameter int SKIP_W  = 4
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              href,
  input  logic              pix_we,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic              mode_cont,
  input  logic [SKIP_W-1:0] skip,
  input  logic [1:0]        buf_release,
  output logic              cap_rst,
  output logic              bank_sel,
  output logic              frame_done,
  output logic              done_bank,
  output logic              done_err,
  output logic [1:0]        bank_full,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_t;

  state_t            state, state_next;
  logic              vs_q, hr_q;
  logic              mode_q, mode_next;
  logic [SKIP_W-1:0] skip_q, skip_q_next;
  logic [SKIP_W-1:0] skip_cnt, skip_cnt_next;
  logic              bank_sel_next;
  logic [1:0]        bank_full_next, set_full;
  logic [7:0]        drop_next;
  logic [10:0]       pix_cnt, pix_next, pix_eff;
  logic [9:0]        line_cnt, line_next, line_upd;
  logic              err, err_next, err_upd;
  logic              stop_pend, stop_next;
  logic              done_next, done_bank_next, done_err_next;
  logic              frame_start, frame_end, line_end;

  // Edges are taken between the registered copy and the live input.
  assign frame_start = vs_q & ~vsync;
  assign frame_end   = ~vs_q & vsync;
  assign line_end    = hr_q & ~href;

  assign cap_rst = (state != CAPTURE);
  assign busy    = (state != IDLE);

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      vs_q       <= 1'b0;
      hr_q       <= 1'b0;
      mode_q     <= 1'b0;
      skip_q     <= '0;
      skip_cnt   <= '0;
      bank_sel   <= 1'b0;
      bank_full  <= 2'b00;
      drop_cnt   <= 8'd0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      err        <= 1'b0;
      stop_pend  <= 1'b0;
      frame_done <= 1'b0;
      done_bank  <= 1'b0;
      done_err   <= 1'b0;
    end else begin
      state      <= state_next;
      vs_q       <= vsync;
      hr_q       <= href;
      mode_q     <= mode_next;
      skip_q     <= skip_q_next;
      skip_cnt   <= skip_cnt_next;
      bank_sel   <= bank_sel_next;
      bank_full  <= bank_full_next;
      drop_cnt   <= drop_next;
      pix_cnt    <= pix_next;
      line_cnt   <= line_next;
      err        <= err_next;
      stop_pend  <= stop_next;
      frame_done <= done_next;
      done_bank  <= done_bank_next;
      done_err   <= done_err_next;
    end
  end

  always_comb begin
    state_next     = state;
    mode_next      = mode_q;
    skip_q_next    = skip_q;
    skip_cnt_next  = skip_cnt;
    bank_sel_next  = bank_sel;
    set_full       = 2'b00;
    drop_next      = drop_cnt;
    pix_next       = pix_cnt;
    line_next      = line_cnt;
    err_next       = err;
    stop_next      = stop_pend;
    done_next      = 1'b0;
    done_bank_next = done_bank;
    done_err_next  = done_err;
    pix_eff        = pix_cnt + 11'(pix_we);
    line_upd       = line_cnt;
    err_upd        = err;

    unique case (state)
      IDLE: begin
        if (cmd_start && !cmd_stop) begin
          mode_next     = mode_cont;
          skip_q_next   = skip;
          skip_cnt_next = '0;
          state_next    = WAIT_VS;
        end
      end
      WAIT_VS: begin
        if (cmd_stop) begin
          state_next = IDLE;
        end else if (frame_start) begin
          if (skip_cnt != '0) begin
            skip_cnt_next = skip_cnt - 1'b1;
          end else if (!bank_full[bank_sel] || !bank_full[~bank_sel]) begin
            bank_sel_next = bank_full[bank_sel] ? ~bank_sel : bank_sel;
            state_next    = CAPTURE;
            pix_next      = '0;
            line_next     = '0;
            err_next      = 1'b0;
            stop_next     = 1'b0;
          end else if (drop_cnt != 8'hFF) begin
            drop_next = drop_cnt + 8'd1;
          end
        end
      end
      CAPTURE: begin
        pix_next = pix_eff;
        if (cmd_stop) stop_next = 1'b1;
        // Line check lands first so a coincident frame end sees the final line count.
        if (line_end) begin
          if (pix_eff != 11'(H_PIX)) err_upd = 1'b1;
          pix_next = '0;
          if (line_cnt != '1) line_upd = line_cnt + 10'd1;
        end
        if (frame_end) begin
          if (line_upd != 10'(V_LINES)) err_upd = 1'b1;
          done_next          = 1'b1;
          done_bank_next     = bank_sel;
          done_err_next      = err_upd;
          set_full[bank_sel] = 1'b1;
          bank_sel_next      = ~bank_sel;
          skip_cnt_next      = skip_q;
          if (!mode_q || stop_pend || cmd_stop) begin
            state_next = IDLE;
            stop_next  = 1'b0;
          end else begin
            state_next = WAIT_VS;
          end
        end
        line_next = line_upd;
        err_next  = err_upd;
      end
      default: state_next = IDLE;
    endcase

    // A completing frame's set wins over a same-cycle release of that bank.
    bank_full_next = (bank_full & ~buf_release) | set_full;
  end

endmodule

// File: tb/tb_ov_frame_ctrl.sv
// Directed bench for ov_frame_ctrl using a reduced 8x4 frame geometry.
module tb_ov_frame_ctrl;

  localparam int H = 8;
  localparam int V = 4;

  logic       pclk = 1'b0;
  logic       reset, vsync, href, pix_we, cmd_start, cmd_stop, mode_cont;
  logic [3:0] skip;
  logic [1:0] buf_release;
  logic       cap_rst, bank_sel, frame_done, done_bank, done_err, busy;
  logic [1:0] bank_full;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  ov_frame_ctrl #(.H_PIX(H), .V_LINES(V), .SKIP_W(4)) dut (
    .pclk(pclk), .reset(reset), .vsync(vsync), .href(href), .pix_we(pix_we),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .mode_cont(mode_cont), .skip(skip),
    .buf_release(buf_release), .cap_rst(cap_rst), .bank_sel(bank_sel),
    .frame_done(frame_done), .done_bank(done_bank), .done_err(done_err),
    .bank_full(bank_full), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic       start;
    logic       mode;
    logic [3:0] skp;
    logic [1:0] rel;
    int         lines;
    int         short_line;
    int         stop_line;
    logic       exp_done;
    logic       exp_bank;
    logic       exp_err;
    logic [1:0] exp_full;
    logic [7:0] exp_drop;
    logic       exp_busy;
  } vec_t;

  vec_t va[9];
  vec_t vb[9];

  function automatic vec_t mk(input logic st, input logic md, input logic [3:0] sk,
                              input logic [1:0] rl, input int ln, input int sh, input int sp,
                              input logic ed, input logic eb, input logic ee,
                              input logic [1:0] ef, input logic [7:0] edr, input logic ebz);
    vec_t v;
    v.start = st; v.mode = md; v.skp = sk; v.rel = rl; v.lines = ln;
    v.short_line = sh; v.stop_line = sp; v.exp_done = ed; v.exp_bank = eb;
    v.exp_err = ee; v.exp_full = ef; v.exp_drop = edr; v.exp_busy = ebz;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One frame of vsync/href/pix_we; returns the outputs seen on the two cycles after vsync rises.
  task automatic run_frame(input int lines, input int short_line, input int stop_line,
                           output logic fd, output logic db, output logic de,
                           output logic cr, output logic fd2);
    @(negedge pclk) vsync = 1'b0;
    repeat (2) @(negedge pclk);
    for (int l = 0; l < lines; l++) begin
      href = 1'b1;
      for (int p = 0; p < ((l == short_line) ? H - 1 : H); p++) begin
        pix_we   = 1'b1;
        cmd_stop = (l == stop_line && p == 0);
        @(negedge pclk);
      end
      pix_we = 1'b0; cmd_stop = 1'b0; href = 1'b0;
      repeat (2) @(negedge pclk);
    end
    vsync = 1'b1;
    @(negedge pclk);
    fd = frame_done; db = done_bank; de = done_err; cr = cap_rst;
    @(negedge pclk);
    fd2 = frame_done;
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic fd, db, de, cr, fd2;
    if (v.rel != 2'b00) begin
      buf_release = v.rel;
      @(negedge pclk) buf_release = 2'b00;
    end
    if (v.start) begin
      cmd_start = 1'b1; mode_cont = v.mode; skip = v.skp;
      @(negedge pclk) cmd_start = 1'b0;
      @(negedge pclk);
    end
    run_frame(v.lines, v.short_line, v.stop_line, fd, db, de, cr, fd2);
    check($sformatf("%s.frame_done", tag), fd, v.exp_done);
    if (v.exp_done) begin
      check($sformatf("%s.done_bank", tag), db, v.exp_bank);
      check($sformatf("%s.done_err", tag), de, v.exp_err);
    end
    check($sformatf("%s.cap_rst_end", tag), cr, 1'b1);
    check($sformatf("%s.done_pulse", tag), fd2, 1'b0);
    check($sformatf("%s.bank_full", tag), bank_full, v.exp_full);
    check($sformatf("%s.drop_cnt", tag), drop_cnt, v.exp_drop);
    check($sformatf("%s.busy", tag), busy, v.exp_busy);
    $display("%s: done=%0b bank=%0b err=%0b full=%b drop=%0d busy=%0b",
             tag, fd, db, de, bank_full, drop_cnt, busy);
    repeat (2) @(negedge pclk);
  endtask

  initial begin
    logic fd, db, de, cr, fd2;
    reset = 1'b1; vsync = 1'b1; href = 1'b0; pix_we = 1'b0; cmd_start = 1'b0;
    cmd_stop = 1'b0; mode_cont = 1'b0; skip = 4'd0; buf_release = 2'b00;

    // start, mode, skip, rel, lines, short, stop, done, bank, err, full, drop, busy
    va[0] = mk(1, 0, 0, 2'b00, 4, -1, -1, 1, 0, 0, 2'b01, 0, 0);
    va[1] = mk(1, 0, 0, 2'b00, 4,  1, -1, 1, 1, 1, 2'b11, 0, 0);
    va[2] = mk(1, 0, 0, 2'b11, 3, -1, -1, 1, 0, 1, 2'b01, 0, 0);
    va[3] = mk(1, 1, 0, 2'b01, 4, -1, -1, 1, 1, 0, 2'b10, 0, 1);
    va[4] = mk(0, 0, 0, 2'b00, 4, -1, -1, 1, 0, 0, 2'b11, 0, 1);
    va[5] = mk(0, 0, 0, 2'b00, 4, -1, -1, 0, 0, 0, 2'b11, 1, 1);
    va[6] = mk(0, 0, 0, 2'b00, 4, -1, -1, 0, 0, 0, 2'b11, 2, 1);
    va[7] = mk(0, 0, 0, 2'b01, 4, -1, -1, 1, 0, 0, 2'b11, 2, 1);
    va[8] = mk(0, 0, 0, 2'b11, 4, -1,  1, 1, 1, 0, 2'b10, 2, 0);

    vb[0] = mk(1, 1, 2, 2'b00, 4, -1, -1, 1, 0, 0, 2'b01, 0, 1);
    vb[1] = mk(0, 0, 0, 2'b01, 4, -1, -1, 0, 0, 0, 2'b00, 0, 1);
    vb[2] = mk(0, 0, 0, 2'b00, 4, -1, -1, 0, 0, 0, 2'b00, 0, 1);
    vb[3] = mk(0, 0, 0, 2'b00, 4, -1, -1, 1, 1, 0, 2'b10, 0, 1);
    vb[4] = mk(0, 0, 0, 2'b10, 4, -1, -1, 0, 0, 0, 2'b00, 0, 1);
    vb[5] = mk(0, 0, 0, 2'b00, 4, -1, -1, 0, 0, 0, 2'b00, 0, 1);
    vb[6] = mk(0, 0, 0, 2'b00, 4, -1, -1, 1, 0, 0, 2'b01, 0, 1);
    vb[7] = mk(0, 0, 0, 2'b01, 4, -1, -1, 0, 0, 0, 2'b00, 0, 1);
    vb[8] = mk(0, 0, 0, 2'b00, 4, -1, -1, 0, 0, 0, 2'b00, 0, 1);

    @(negedge pclk);
    check("reset.cap_rst", cap_rst, 1'b1);
    check("reset.outs", {bank_sel, frame_done, done_bank, done_err, bank_full, busy, drop_cnt}, 0);
    $display("reset: cap_rst=%0b busy=%0b full=%b", cap_rst, busy, bank_full);
    @(negedge pclk) reset = 1'b0;
    repeat (2) @(negedge pclk);

    for (int i = 0; i < 9; i++) apply(va[i], $sformatf("A%0d", i));

    // Asynchronous reset in the middle of a captured line.
    cmd_start = 1'b1; mode_cont = 1'b1; skip = 4'd0;
    @(negedge pclk) cmd_start = 1'b0;
    @(negedge pclk) vsync = 1'b0;
    repeat (2) @(negedge pclk);
    href = 1'b1; pix_we = 1'b1;
    repeat (3) @(negedge pclk);
    check("rst_mid.pre_cap_rst", cap_rst, 1'b0);
    check("rst_mid.pre_bank_sel", bank_sel, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("rst_mid.cap_rst", cap_rst, 1'b1);
    check("rst_mid.outs", {bank_sel, frame_done, done_bank, done_err, bank_full, busy, drop_cnt}, 0);
    $display("rst_mid: cap_rst=%0b busy=%0b full=%b drop=%0d", cap_rst, busy, bank_full, drop_cnt);
    @(negedge pclk) reset = 1'b0; pix_we = 1'b0; href = 1'b0;
    repeat (2) @(negedge pclk);
    vsync = 1'b1;
    @(negedge pclk);
    check("rst_mid.no_done", frame_done, 1'b0);
    repeat (2) @(negedge pclk);

    for (int i = 0; i < 9; i++) apply(vb[i], $sformatf("B%0d", i));

    // Stop while waiting for vsync, then a coincident start/stop.
    cmd_stop = 1'b1;
    @(negedge pclk) cmd_stop = 1'b0;
    check("stop_wait.busy", busy, 1'b0);
    cmd_start = 1'b1; cmd_stop = 1'b1; mode_cont = 1'b1;
    @(negedge pclk) cmd_start = 1'b0; cmd_stop = 1'b0;
    check("start_stop.busy", busy, 1'b0);
    run_frame(4, -1, -1, fd, db, de, cr, fd2);
    check("idle_frame.no_done", fd, 1'b0);
    $display("stop_wait: busy=%0b done=%0b", busy, fd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ov_frame_ctrl.md
Name: ov_frame_ctrl

Overview:
- Frame-level capture controller for the OV camera pixel path.
- Sequences single-shot or continuous capture and applies frame decimation.
- Gates the pixel capture block through its reset input and runs a two-bank (ping-pong) frame-buffer scheduler with consumer release handshake.
- Checks line and pixel geometry per frame and reports done, error and dropped-frame status. Runs entirely in the pclk domain.

Parameters:
- H_PIX, 640, pixel write strobes expected per line
- V_LINES, 480, lines expected per frame
- SKIP_W, 4, width of decimation field

Ports:
- pclk  in  1  camera pixel clock
- reset  in  1  asynchronous, active-high
- vsync  in  1  camera vsync (high = vertical blanking)
- href  in  1  camera line valid
- pix_we  in  1  pixel write strobe from capture block, one per completed pixel
- cmd_start  in  1  one-cycle pulse, arm capture
- cmd_stop  in  1  one-cycle pulse, stop capture
- mode_cont  in  1  1 = continuous, 0 = single-shot (sampled on cmd_start)
- skip  in  SKIP_W  capture 1 of every skip+1 frames (sampled on cmd_start)
- buf_release  in  2  one-cycle pulse per bank, consumer frees bank
- cap_rst  out  1  reset to capture block; high whenever not in CAPTURE
- bank_sel  out  1  bank currently/next written
- frame_done  out  1  one-cycle pulse at end of captured frame
- done_bank  out  1  bank that just completed, valid with frame_done
- done_err  out  1  geometry error for completed frame, valid with frame_done
- bank_full  out  2  per-bank full flags
- busy  out  1  high in WAIT_VS or CAPTURE
- drop_cnt  out  8  frames dropped for lack of free bank, saturating

Behaviour:
- Reset values: cap_rst=1; all other outputs 0; state IDLE; all counters 0.
- vsync and href are registered once (vs_q, hr_q). Frame start = vs_q 1->0; frame end = vs_q 0->1; line end = hr_q 1->0.
- States: IDLE, WAIT_VS, CAPTURE.
- IDLE:
  - On cmd_start: latch mode_cont and skip, load skip_cnt=0, go to WAIT_VS.
  - cmd_stop has no effect.
- WAIT_VS:
  - cmd_stop -> IDLE immediately.
  - On frame start:
    - If skip_cnt != 0: decrement skip_cnt, stay.
    - Else if bank_full[bank_sel]=0: go to CAPTURE, clear line/pixel counters and err flag.
    - Else if bank_full[~bank_sel]=0: toggle bank_sel, go to CAPTURE.
    - Else: drop_cnt+1 (saturate at 255), stay; skip_cnt is not reloaded.
- CAPTURE:
  - cap_rst=0 from the cycle after the frame-start edge was detected.
  - pix_we increments pix_cnt (11b).
  - On line end: compare pix_cnt with H_PIX (mismatch sets err), then clear pix_cnt and increment line_cnt (10b, saturating).
  - cmd_stop sets stop_pend; the frame always finishes.
  - On frame end:
    - Set err if line_cnt != V_LINES.
    - Pulse frame_done with done_bank=bank_sel and done_err=err.
    - Set bank_full[bank_sel], toggle bank_sel, reload skip_cnt=skip.
    - Next state: IDLE if mode_cont=0 or stop_pend (clear stop_pend), else WAIT_VS.
    - cap_rst returns to 1 in the cycle after frame end.
- A line end and a frame end in the same cycle: the line check is applied first, then the frame check uses the updated line_cnt.
- buf_release[i] clears bank_full[i] in any state. Release and set of the same bank in the same cycle: set wins. Release of a non-full bank is ignored.
- cmd_start while busy: ignored. cmd_start and cmd_stop in the same cycle: stop wins; stay in or return to IDLE.
- cmd_start does not clear bank_full or drop_cnt; only reset clears them.
- Asynchronous reset mid-frame: all state and counters go to their reset values immediately and cap_rst=1. No frame_done is issued.

Test Plan:
- Single-shot: cmd_start with mode_cont=0, skip=0; one 480x640 frame -> one frame_done, done_bank=0, done_err=0, bank_full=01; state returns to IDLE; cap_rst=1 one cycle after vsync rises.
- Continuous, skip=2, 9 frames, consumer releases each bank on frame_done -> frames 1, 4 and 7 captured; done_bank sequence 0, 1, 0.
- Continuous, no buf_release -> frames to bank 0 then bank 1, then every later frame start increments drop_cnt; after release of bank 0, the next frame is written to bank 0.
- Geometry error: one line with 639 strobes -> done_err=1. Separately, a 479-line frame -> done_err=1.
- cmd_stop mid-CAPTURE -> current frame completes with frame_done, then IDLE. cmd_stop in WAIT_VS -> IDLE next cycle with no frame_done.
- Reset asserted mid-line -> all outputs at reset values in the same cycle. A later cmd_start captures normally into bank 0.
